// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: splits scalar/vector loads and stores into 32b Avalon-MM beats,
// stalls the pipeline while in flight and assembles the read result. Rev 1.0
`default_nettype none

module vector_mem_sequencer #(
  parameter int VBEATS      = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  req_vector,
  input  logic [31:0]           req_addr,
  input  logic [32*VBEATS-1:0]  req_wdata,
  output logic                  stall_all,
  output logic                  rsp_valid,
  output logic [32*VBEATS-1:0]  rsp_rdata,
  output logic                  err_timeout,
  output logic [31:0]           vstall_cycles,
  output logic [31:0]           avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  output logic [3:0]            avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int DW = 32 * VBEATS;
  localparam int BW = (VBEATS > 1) ? $clog2(VBEATS) : 1;
  localparam logic [BW-1:0] LAST_VEC = BW'(VBEATS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   beat;
  logic            wr, vec;
  logic [31:0]     base;
  logic [DW-1:0]   wdata;
  logic [31:0]     wd_cnt;
  logic            beat_done, capture, timeout_hit, last_beat, wd_expired;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  assign last_beat  = vec ? (beat == LAST_VEC) : (beat == '0);
  assign wd_expired = (TIMEOUT_CYC > 0) && (wd_cnt == 32'(TIMEOUT_CYC - 1));

  assign avm_address    = base + {{(30-BW){1'b0}}, beat, 2'b00};
  assign avm_writedata  = wdata[32*beat +: 32];
  assign avm_byteenable = 4'b1111;

  always_comb begin
    state_nx    = state;
    beat_done   = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    stall_all   = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        stall_all = req_valid;
        if (req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        stall_all = 1'b1;
        avm_read  = ~wr;
        avm_write = wr;
        if (!avm_waitrequest) begin
          if (wr) beat_done = 1'b1;
          else    state_nx  = WAIT_RD;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
        end
      end
      WAIT_RD: begin
        stall_all = 1'b1;
        if (avm_readdatavalid) begin
          capture   = 1'b1;
          beat_done = 1'b1;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (beat_done)   state_nx = last_beat ? DONE : ISSUE;
    if (timeout_hit) state_nx = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      wr            <= 1'b0;
      vec           <= 1'b0;
      base          <= '0;
      wdata         <= '0;
      rsp_rdata     <= '0;
      err_timeout   <= 1'b0;
      vstall_cycles <= '0;
      wd_cnt        <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wr        <= req_write;
        vec       <= req_vector;
        base      <= {req_addr[31:2], 2'b00};
        wdata     <= req_wdata;
        rsp_rdata <= '0;
        beat      <= '0;
      end
      if (capture) rsp_rdata[32*beat +: 32] <= avm_readdata;
      if (beat_done && !last_beat) beat <= beat + 1'b1;
      if (timeout_hit) err_timeout <= 1'b1;
      if (stall_all && vstall_cycles != 32'hFFFF_FFFF)
        vstall_cycles <= vstall_cycles + 32'd1;
      // Watchdog restarts whenever a beat phase is (re)entered.
      if (state_nx != state || beat_done) wd_cnt <= '0;
      else if (wd_cnt != 32'hFFFF_FFFF)   wd_cnt <= wd_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: directed self-checking bench for vector_mem_sequencer. Rev 1.0
`default_nettype none

module tb_vector_mem_sequencer;

  logic         clk, reset;
  logic         req_valid, req_write, req_vector;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         stall_all, rsp_valid, err_timeout;
  logic [127:0] rsp_rdata;
  logic [31:0]  vstall_cycles, avm_address, avm_writedata, avm_readdata;
  logic         avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]   avm_byteenable;

  int total = 0;
  int bad   = 0;

  vector_mem_sequencer #(.VBEATS(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_vector(req_vector),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_all(stall_all), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_timeout(err_timeout), .vstall_cycles(vstall_cycles),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic c1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic c32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic c128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_vector = 1'b0;
    req_addr = '0; req_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset = 1'b0; #1;
    c1("rst_stall", stall_all, 1'b0);
    c1("rst_rsp_valid", rsp_valid, 1'b0);
    c1("rst_read", avm_read, 1'b0);
    c1("rst_write", avm_write, 1'b0);
    c128("rst_rdata", rsp_rdata, 128'h0);
    c1("rst_err", err_timeout, 1'b0);
    c32("rst_vstall", vstall_cycles, 32'd0);
    c32("rst_byteen", {28'h0, avm_byteenable}, 32'hF);

    // T1: scalar load, no waits, readdatavalid one cycle after accept
    req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b0; req_addr = 32'h100; #1;
    c1("t1_stall_idle", stall_all, 1'b1);
    step(); req_valid = 1'b0; #1;
    c1("t1_read", avm_read, 1'b1);
    c1("t1_write", avm_write, 1'b0);
    c32("t1_addr", avm_address, 32'h100);
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF; #1;
    c1("t1_wait_read", avm_read, 1'b0);
    c1("t1_wait_stall", stall_all, 1'b1);
    step(); avm_readdatavalid = 1'b0; #1;
    c1("t1_rsp_valid", rsp_valid, 1'b1);
    c1("t1_done_stall", stall_all, 1'b0);
    c128("t1_rdata", rsp_rdata, 128'hDEADBEEF);
    c32("t1_vstall", vstall_cycles, 32'd3);
    step(); #1;
    c1("t1_rsp_pulse_end", rsp_valid, 1'b0);

    // T2: vector store, beat 1 held by two waitrequest cycles
    req_valid = 1'b1; req_write = 1'b1; req_vector = 1'b1; req_addr = 32'h200;
    req_wdata = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}; #1;
    step(); req_valid = 1'b0; req_wdata = '0; req_addr = '0; #1;
    c1("t2_write_b0", avm_write, 1'b1);
    c1("t2_read_b0", avm_read, 1'b0);
    c32("t2_addr_b0", avm_address, 32'h200);
    c32("t2_wd_b0", avm_writedata, 32'hAAAA0001);
    step(); avm_waitrequest = 1'b1; #1;
    c32("t2_addr_b1a", avm_address, 32'h204);
    c32("t2_wd_b1a", avm_writedata, 32'hBBBB0002);
    step(); #1;
    c32("t2_addr_b1b", avm_address, 32'h204);
    c1("t2_write_b1b", avm_write, 1'b1);
    step(); avm_waitrequest = 1'b0; #1;
    c32("t2_addr_b1c", avm_address, 32'h204);
    c32("t2_wd_b1c", avm_writedata, 32'hBBBB0002);
    step(); #1;
    c32("t2_addr_b2", avm_address, 32'h208);
    c32("t2_wd_b2", avm_writedata, 32'hCCCC0003);
    step(); #1;
    c32("t2_addr_b3", avm_address, 32'h20C);
    c32("t2_wd_b3", avm_writedata, 32'hDDDD0004);
    step(); #1;
    c1("t2_rsp_valid", rsp_valid, 1'b1);
    c1("t2_done_write", avm_write, 1'b0);
    c128("t2_rdata", rsp_rdata, 128'h0);
    c32("t2_vstall", vstall_cycles, 32'd10);
    step();

    // T3: vector load with address wrap, latencies 1,3,1,2
    req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b1; req_addr = 32'hFFFF_FFF8; #1;
    step(); req_valid = 1'b0; #1;
    c1("t3_read_b0", avm_read, 1'b1);
    c32("t3_addr_b0", avm_address, 32'hFFFF_FFF8);
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'h11111111; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    c32("t3_addr_b1", avm_address, 32'hFFFF_FFFC);
    step(); #1;
    step(); #1;
    c1("t3_wait_b1", avm_read, 1'b0);
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'h22222222; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    c32("t3_addr_b2", avm_address, 32'h0);
    c1("t3_read_b2", avm_read, 1'b1);
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'h33333333; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    c32("t3_addr_b3", avm_address, 32'h4);
    step(); #1;
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'h44444444; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    c1("t3_rsp_valid", rsp_valid, 1'b1);
    c128("t3_rdata", rsp_rdata, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    c32("t3_vstall", vstall_cycles, 32'd22);
    step();
    // stray readdatavalid while idle must not touch the result
    avm_readdatavalid = 1'b1; avm_readdata = 32'hBADBAD00; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    c128("t3_stray_ignored", rsp_rdata, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    c1("t3_stray_stall", stall_all, 1'b0);

    // T4: load whose data never arrives; watchdog of 8 cycles
    req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b0; req_addr = 32'h300; #1;
    step(); req_valid = 1'b0; #1;
    c32("t4_addr", avm_address, 32'h300);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      c1("t4_wait_stall", stall_all, 1'b1);
      c1("t4_wait_err", err_timeout, 1'b0);
    end
    step(); #1;
    c1("t4_rsp_valid", rsp_valid, 1'b1);
    c1("t4_err", err_timeout, 1'b1);
    c128("t4_rdata", rsp_rdata, 128'h0);
    c32("t4_vstall", vstall_cycles, 32'd32);
    step(); #1;
    c1("t4_err_sticky", err_timeout, 1'b1);
    c1("t4_idle_stall", stall_all, 1'b0);
    c1("t4_idle_rsp", rsp_valid, 1'b0);

    // T5: reset during beat 2 of a vector load, late data afterwards
    req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b1; req_addr = 32'h400; #1;
    step(); req_valid = 1'b0; #1;
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'hA0A0A0A0; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'hA1A1A1A1; #1;
    step(); avm_readdatavalid = 1'b0; #1;
    c32("t5_addr_b2", avm_address, 32'h408);
    c1("t5_read_b2", avm_read, 1'b1);
    step(); reset = 1'b1; #1;
    c1("t5_wait_stall", stall_all, 1'b1);
    step(); reset = 1'b0; #1;
    c1("t5_rst_read", avm_read, 1'b0);
    c1("t5_rst_stall", stall_all, 1'b0);
    c1("t5_rst_rsp", rsp_valid, 1'b0);
    c1("t5_rst_err", err_timeout, 1'b0);
    c32("t5_rst_vstall", vstall_cycles, 32'd0);
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'h1A7E1A7E; #1;
    c1("t5_late_rsp", rsp_valid, 1'b0);
    step(); avm_readdatavalid = 1'b0; #1;
    c1("t5_late_rsp2", rsp_valid, 1'b0);
    c128("t5_late_rdata", rsp_rdata, 128'h0);
    c1("t5_late_stall", stall_all, 1'b0);

    // T6: back-to-back scalar store then load with req_valid held
    req_valid = 1'b1; req_write = 1'b1; req_vector = 1'b0; req_addr = 32'h500;
    req_wdata = 128'h12345678; #1;
    c1("t6_stall_idle1", stall_all, 1'b1);
    step(); req_write = 1'b0; req_addr = 32'h507; req_wdata = '0; #1;
    c1("t6_st_write", avm_write, 1'b1);
    c1("t6_st_read", avm_read, 1'b0);
    c32("t6_st_addr", avm_address, 32'h500);
    c32("t6_st_wd", avm_writedata, 32'h12345678);
    step(); #1;
    c1("t6_st_rsp", rsp_valid, 1'b1);
    c1("t6_st_done_stall", stall_all, 1'b0);
    step(); #1;
    c1("t6_stall_idle2", stall_all, 1'b1);
    c1("t6_idle_rsp", rsp_valid, 1'b0);
    step(); #1;
    c1("t6_ld_read", avm_read, 1'b1);
    c32("t6_ld_addr", avm_address, 32'h504);
    step(); avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFEF00D; #1;
    step(); avm_readdatavalid = 1'b0; req_valid = 1'b0; #1;
    c1("t6_ld_rsp", rsp_valid, 1'b1);
    c128("t6_ld_rdata", rsp_rdata, 128'hCAFEF00D);
    c32("t6_vstall", vstall_cycles, 32'd5);
    step(); #1;
    c1("t6_end_stall", stall_all, 1'b0);
    c32("t6_end_vstall", vstall_cycles, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
